// File: rtl/safe_mode_controller.sv
// safe_mode_controller: fault-driven safe-mode sequencer.
// NORMAL -> HOLD -> SAFE -> RECOVER -> NORMAL, with a sticky LOCKOUT for
// fatal faults. Every output is registered, so a fault sampled at a clock
// edge shows up on the outputs right after that edge.
// Optional macro SAFE_FAULT_LOG_EN adds the fault counter, the last-code
// capture and escalation to LOCKOUT once MAX_FAULTS faults are accepted.
// Without the macro, fault_count and last_fault_code read as zero.
module safe_mode_controller #(
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned RECOVER_CYCLES = 8,
    parameter int unsigned MAX_FAULTS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fault_valid,
    input  logic [3:0] fault_code,
    input  logic       fault_fatal,
    input  logic       clear_req,
    output logic       safe_mode,
    output logic       pc_write_safe,
    output logic       reg_write_safe,
    output logic       mem_write_safe,
    output logic       lockout,
    output logic [2:0] state_o,
    output logic [7:0] fault_count,
    output logic [3:0] last_fault_code
);

    typedef enum logic [2:0] {
        ST_NORMAL  = 3'd0,
        ST_HOLD    = 3'd1,
        ST_SAFE    = 3'd2,
        ST_RECOVER = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] RECOVER_LAST = 8'(RECOVER_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fault_accept;
    logic       escalate;

    // LOCKOUT swallows faults; everywhere else a reported fault is accepted.
    assign fault_accept = fault_valid && (state_q != ST_LOCKOUT);

`ifdef SAFE_FAULT_LOG_EN
    logic [7:0] fault_count_q;
    logic [3:0] last_code_q;
    logic [7:0] count_inc;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign count_inc = sat_inc(fault_count_q);
    // Escalation looks at the count this fault would produce.
    assign escalate  = fault_accept && (32'(count_inc) >= MAX_FAULTS);

    // Fault log: saturating count and most recent code of accepted faults.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count_q <= 8'd0;
            last_code_q   <= 4'd0;
        end else if (fault_accept) begin
            fault_count_q <= count_inc;
            last_code_q   <= fault_code;
        end
    end

    assign fault_count     = fault_count_q;
    assign last_fault_code = last_code_q;
`else
    logic unused_fault_code;

    assign unused_fault_code = ^fault_code;
    assign escalate          = 1'b0;
    assign fault_count       = 8'd0;
    assign last_fault_code   = 4'd0;
`endif

    // Next-state selection and dwell counter; the counter clears on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = 8'd0;
        case (state_q)
            ST_NORMAL: begin
                if (fault_valid)
                    state_d = (fault_fatal || escalate) ? ST_LOCKOUT : ST_HOLD;
            end
            ST_HOLD: begin
                if (fault_valid && (fault_fatal || escalate))
                    state_d = ST_LOCKOUT;
                else if (cnt_q == HOLD_LAST)
                    state_d = ST_SAFE;
            end
            ST_SAFE: begin
                // A fault in the same cycle as clear_req wins; the clear is dropped.
                if (fault_valid) begin
                    if (fault_fatal || escalate)
                        state_d = ST_LOCKOUT;
                end else if (clear_req) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (fault_valid)
                    state_d = (fault_fatal || escalate) ? ST_LOCKOUT : ST_HOLD;
                else if (cnt_q == RECOVER_LAST)
                    state_d = ST_NORMAL;
            end
            ST_LOCKOUT: state_d = ST_LOCKOUT;
            default:    state_d = ST_NORMAL;
        endcase

        if ((state_d == state_q) && ((state_q == ST_HOLD) || (state_q == ST_RECOVER)))
            cnt_d = cnt_q + 8'd1;
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output registers decoded from the next state so they line up with state_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            safe_mode      <= 1'b0;
            pc_write_safe  <= 1'b0;
            reg_write_safe <= 1'b0;
            mem_write_safe <= 1'b0;
            lockout        <= 1'b0;
        end else begin
            safe_mode      <= (state_d != ST_NORMAL);
            pc_write_safe  <= (state_d == ST_SAFE);
            reg_write_safe <= 1'b0;
            mem_write_safe <= 1'b0;
            lockout        <= (state_d == ST_LOCKOUT);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_safe_mode_controller.sv
// Directed bench for safe_mode_controller with default parameters
// (HOLD_CYCLES=4, RECOVER_CYCLES=8, MAX_FAULTS=3). Expectations follow
// whichever build is compiled (SAFE_FAULT_LOG_EN defined or not).
module tb_safe_mode_controller;

`ifdef SAFE_FAULT_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fault_valid = 1'b0;
    logic [3:0] fault_code = 4'd0;
    logic       fault_fatal = 1'b0;
    logic       clear_req = 1'b0;
    logic       safe_mode, pc_write_safe, reg_write_safe, mem_write_safe, lockout;
    logic [2:0] state_o;
    logic [7:0] fault_count;
    logic [3:0] last_fault_code;

    int checks = 0;
    int errors = 0;

    safe_mode_controller dut (
        .clk(clk), .rst(rst),
        .fault_valid(fault_valid), .fault_code(fault_code),
        .fault_fatal(fault_fatal), .clear_req(clear_req),
        .safe_mode(safe_mode), .pc_write_safe(pc_write_safe),
        .reg_write_safe(reg_write_safe), .mem_write_safe(mem_write_safe),
        .lockout(lockout), .state_o(state_o),
        .fault_count(fault_count), .last_fault_code(last_fault_code)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lg(input logic [31:0] v);
        return LOG ? v : 32'd0;
    endfunction

    task automatic fault(input logic [3:0] code, input logic fatal);
        fault_valid = 1'b1;
        fault_code  = code;
        fault_fatal = fatal;
        step();
        fault_valid = 1'b0;
        fault_fatal = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_safe_mode", 32'(safe_mode), 0);
        chk("rst_lockout", 32'(lockout), 0);
        chk("rst_pc_we", 32'(pc_write_safe), 0);
        chk("rst_count", 32'(fault_count), 0);
        chk("rst_code", 32'(last_fault_code), 0);
        step();
        chk("normal_idle", 32'(state_o), 0);

        // First fault 0x5 -> four HOLD cycles, then SAFE
        fault(4'h5, 1'b0);
        chk("f1_state", 32'(state_o), 1);
        chk("f1_safe_mode", 32'(safe_mode), 1);
        chk("f1_pc_we", 32'(pc_write_safe), 0);
        chk("f1_count", 32'(fault_count), lg(1));
        chk("f1_code", 32'(last_fault_code), lg(5));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold1_dwell", 32'(state_o), 1);
        end
        step();
        chk("safe1_state", 32'(state_o), 2);
        chk("safe1_safe_mode", 32'(safe_mode), 1);
        chk("safe1_pc_we", 32'(pc_write_safe), 1);
        chk("safe1_reg_we", 32'(reg_write_safe), 0);
        chk("safe1_mem_we", 32'(mem_write_safe), 0);
        step();
        chk("safe1_stay", 32'(state_o), 2);

        // clear_req -> RECOVER; fault 0x2 in RECOVER cycle 3 -> fresh HOLD
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("rec1_state", 32'(state_o), 3);
        chk("rec1_pc_we", 32'(pc_write_safe), 0);
        step();
        step();
        chk("rec1_cycle3", 32'(state_o), 3);
        fault(4'h2, 1'b0);
        chk("f2_state", 32'(state_o), 1);
        chk("f2_count", 32'(fault_count), lg(2));
        chk("f2_code", 32'(last_fault_code), lg(2));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold2_dwell", 32'(state_o), 1);
        end
        step();
        chk("safe2_state", 32'(state_o), 2);

        // Full RECOVER: eight cycles then NORMAL
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("rec2_state", 32'(state_o), 3);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("rec2_dwell", 32'(state_o), 3);
        end
        step();
        chk("rec2_done_state", 32'(state_o), 0);
        chk("rec2_done_safe_mode", 32'(safe_mode), 0);
        chk("rec2_done_pc_we", 32'(pc_write_safe), 0);
        // clear_req outside SAFE is ignored
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("clear_in_normal", 32'(state_o), 0);

        // Third non-fatal fault 0x7
        fault(4'h7, 1'b0);
        chk("f3_state", 32'(state_o), LOG ? 4 : 1);
        chk("f3_lockout", 32'(lockout), LOG ? 1 : 0);
        chk("f3_safe_mode", 32'(safe_mode), 1);
        chk("f3_count", 32'(fault_count), lg(3));
        chk("f3_code", 32'(last_fault_code), lg(7));
        // In LOCKOUT (log build) clear_req and faults have no effect
        clear_req   = 1'b1;
        fault_valid = 1'b1;
        fault_code  = 4'h9;
        step();
        step();
        clear_req   = 1'b0;
        fault_valid = 1'b0;
        if (LOG) begin
            chk("lock_stay_state", 32'(state_o), 4);
            chk("lock_stay_count", 32'(fault_count), 3);
            chk("lock_stay_code", 32'(last_fault_code), 7);
            chk("lock_pc_we", 32'(pc_write_safe), 0);
        end

        // rst wins over a simultaneous fault, also out of LOCKOUT
        rst         = 1'b1;
        fault_valid = 1'b1;
        fault_fatal = 1'b1;
        step();
        rst         = 1'b0;
        fault_valid = 1'b0;
        fault_fatal = 1'b0;
        chk("rst2_state", 32'(state_o), 0);
        chk("rst2_lockout", 32'(lockout), 0);
        chk("rst2_count", 32'(fault_count), 0);
        chk("rst2_code", 32'(last_fault_code), 0);

        // Five consecutive non-fatal fault cycles, code 0xA
        fault_valid = 1'b1;
        fault_code  = 4'hA;
        for (int i = 0; i < 5; i++) step();
        fault_valid = 1'b0;
        chk("five_state", 32'(state_o), LOG ? 4 : 2);
        chk("five_lockout", 32'(lockout), LOG ? 1 : 0);
        chk("five_count", 32'(fault_count), lg(3));
        chk("five_code", 32'(last_fault_code), lg(10));

        // SAFE with fault and clear_req together: fault wins
        rst = 1'b1;
        step();
        rst = 1'b0;
        fault(4'h1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("safe3_state", 32'(state_o), 2);
        fault_valid = 1'b1;
        fault_code  = 4'h3;
        clear_req   = 1'b1;
        step();
        fault_valid = 1'b0;
        clear_req   = 1'b0;
        chk("both_state", 32'(state_o), 2);
        chk("both_count", 32'(fault_count), lg(2));
        chk("both_code", 32'(last_fault_code), lg(3));
        step();
        chk("both_clear_dropped", 32'(state_o), 2);

        // Fatal fault from NORMAL -> LOCKOUT next cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        fault(4'hF, 1'b1);
        chk("fatal_state", 32'(state_o), 4);
        chk("fatal_lockout", 32'(lockout), 1);
        chk("fatal_safe_mode", 32'(safe_mode), 1);
        chk("fatal_count", 32'(fault_count), lg(1));
        chk("fatal_code", 32'(last_fault_code), lg(15));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
